// File: rtl/cpu_pkg.sv
// Shared CPU types: instruction phase encoding and default timing widths.
package cpu_pkg;

  typedef enum logic [1:0] {
    PH_ADDR = 2'd0,
    PH_OP   = 2'd1,
    PH_INT  = 2'd2
  } cpu_phase_t;

  localparam int TIMING_W         = 3;
  localparam int INT_ENTRY_CYCLES = 7;

endpackage

// File: rtl/cpu_timing_sequencer.sv
// Sequences addressing, operation and interrupt-entry phases; emits the T-index within each phase.
// Zero added latency (outputs from state plus live code at T0); ready=0 freezes all state.
module cpu_timing_sequencer
  import cpu_pkg::*;
#(
  parameter int TW         = TIMING_W,
  parameter int INT_CYCLES = INT_ENTRY_CYCLES,
  parameter int CW         = 4
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          ready,
  input  logic [TW-1:0] addressTimingCode,
  input  logic [TW-1:0] opTimingCode,
  input  logic          interruptPending,
  output logic [TW-1:0] timeOut,
  output cpu_phase_t    phase,
  output logic          isAddressing,
  output logic          isInterrupt,
  output logic          phaseStart,
  output logic          lastCycle,
  output logic [CW-1:0] instrCycles
);

  localparam logic [TW-1:0] INT_LEN = TW'(INT_CYCLES - 1);

  logic [1:0]    phase_q, phase_d;
  logic [TW-1:0] count_q, count_d;
  logic [TW-1:0] len_q, len_d;
  logic [CW-1:0] instr_q, instr_d;
  logic [TW-1:0] live_len, eff_len;
  logic [CW-1:0] instr_inc;
  logic          last;

  assign instr_inc = (&instr_q) ? instr_q : instr_q + CW'(1);

  always_comb begin
    live_len = '0;
    case (phase_q)
      PH_ADDR: live_len = addressTimingCode;
      PH_OP:   live_len = opTimingCode;
      PH_INT:  live_len = INT_LEN;
      default: live_len = '0;
    endcase
    // The decoder's code is only trusted at T0; afterwards the latched copy governs.
    eff_len = (count_q == '0) ? live_len : len_q;
    last    = (count_q == eff_len);
  end

  always_comb begin
    phase_d = phase_q;
    count_d = count_q;
    len_d   = len_q;
    instr_d = instr_q;
    if (ready) begin
      if (count_q == '0) len_d = live_len;
      if (!last && phase_q != 2'b11) begin
        count_d = count_q + TW'(1);
        instr_d = instr_inc;
      end else begin
        count_d = '0;
        case (phase_q)
          PH_ADDR: begin
            phase_d = PH_OP;
            instr_d = instr_inc;
          end
          PH_OP: begin
            if (interruptPending) begin
              phase_d = PH_INT;
              instr_d = instr_inc;
            end else begin
              phase_d = PH_ADDR;
              instr_d = '0;
            end
          end
          default: begin
            phase_d = PH_ADDR;
            instr_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      phase_q <= PH_ADDR;
      count_q <= '0;
      len_q   <= '0;
      instr_q <= '0;
    end else begin
      phase_q <= phase_d;
      count_q <= count_d;
      len_q   <= len_d;
      instr_q <= instr_d;
    end
  end

  assign timeOut      = count_q;
  assign phase        = cpu_phase_t'(phase_q);
  assign isAddressing = (phase_q == PH_ADDR);
  assign isInterrupt  = (phase_q == PH_INT);
  assign phaseStart   = (count_q == '0);
  assign lastCycle    = last;
  assign instrCycles  = instr_q;

endmodule

// File: tb/tb_cpu_timing_sequencer.sv
// Bench for cpu_timing_sequencer: instruction-level plans expanded into expected per-cycle T-states.
module tb_cpu_timing_sequencer;
  import cpu_pkg::*;

  localparam int INTC   = 7;
  localparam int IC_MAX = 15;

  logic       clk = 1'b0;
  logic       nrst;
  logic       ready;
  logic [2:0] addr_c;
  logic [2:0] op_c;
  logic       irq;
  logic [2:0] time_out;
  cpu_phase_t phase;
  logic       is_addr, is_int, phase_start, last_cycle;
  logic [3:0] instr_cycles;

  int total = 0;
  int bad   = 0;

  cpu_phase_t force_ph = PH_ADDR;
  int         force_t  = -1;
  int         force_n  = 0;
  int         late_op  = -1;

  cpu_timing_sequencer #(.TW(3), .INT_CYCLES(INTC), .CW(4)) dut (
    .clk               (clk),
    .nrst              (nrst),
    .ready             (ready),
    .addressTimingCode (addr_c),
    .opTimingCode      (op_c),
    .interruptPending  (irq),
    .timeOut           (time_out),
    .phase             (phase),
    .isAddressing      (is_addr),
    .isInterrupt       (is_int),
    .phaseStart        (phase_start),
    .lastCycle         (last_cycle),
    .instrCycles       (instr_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_rst(input bit exp_last);
    chk("rst_phase", 32'(phase), 32'(PH_ADDR));
    chk("rst_timeOut", 32'(time_out), 0);
    chk("rst_isAddressing", 32'(is_addr), 1);
    chk("rst_isInterrupt", 32'(is_int), 0);
    chk("rst_phaseStart", 32'(phase_start), 1);
    chk("rst_lastCycle", 32'(last_cycle), 32'(exp_last));
    chk("rst_instrCycles", 32'(instr_cycles), 0);
  endtask

  // One planned T-state, possibly stretched by stall cycles held at ready=0.
  task automatic do_cycle(input cpu_phase_t ph, input int t, input int len, input int ic,
                          input int a, input int o, input bit irq_v,
                          input int stall_pct, input int noise);
    int nst;
    bit t0, is_last;
    int ic_sat;
    t0      = (t == 0);
    is_last = (t == len);
    ic_sat  = (ic > IC_MAX) ? IC_MAX : ic;
    if (ph == force_ph && t == force_t) nst = force_n;
    else nst = (int'($urandom_range(99)) < stall_pct) ? int'($urandom_range(3, 1)) : 0;
    for (int s = nst; s >= 0; s--) begin
      @(negedge clk);
      ready  = (s == 0);
      addr_c = (ph == PH_ADDR && t0) ? 3'(a) : 3'($urandom);
      if (ph == PH_OP && t0) op_c = 3'(o);
      else if (late_op >= 0) op_c = 3'(late_op);
      else op_c = 3'($urandom);
      if (ph == PH_OP && is_last && s == 0) irq = irq_v;
      else if (noise == 1) irq = 1'($urandom);
      else if (noise == 2) irq = (ph == PH_OP && t0);
      else irq = 1'b0;
      #1;
      chk("phase", 32'(phase), 32'(ph));
      chk("timeOut", 32'(time_out), 32'(t));
      chk("isAddressing", 32'(is_addr), 32'(ph == PH_ADDR));
      chk("isInterrupt", 32'(is_int), 32'(ph == PH_INT));
      chk("phaseStart", 32'(phase_start), 32'(t0));
      chk("lastCycle", 32'(last_cycle), 32'(is_last));
      chk("instrCycles", 32'(instr_cycles), 32'(ic_sat));
    end
  endtask

  task automatic run_instr(input int a, input int o, input bit irq_v,
                           input int stall_pct, input int noise);
    int ic = 0;
    for (int i = 0; i <= a; i++) begin
      do_cycle(PH_ADDR, i, a, ic, a, o, irq_v, stall_pct, noise);
      ic++;
    end
    for (int j = 0; j <= o; j++) begin
      do_cycle(PH_OP, j, o, ic, a, o, irq_v, stall_pct, noise);
      ic++;
    end
    if (irq_v) begin
      for (int k = 0; k < INTC; k++) begin
        do_cycle(PH_INT, k, INTC - 1, ic, a, o, irq_v, stall_pct, noise);
        ic++;
      end
    end
  endtask

  initial begin
    nrst   = 1'b0;
    ready  = 1'b1;
    addr_c = 3'd0;
    op_c   = 3'd0;
    irq    = 1'b0;

    #2;
    chk_rst(1'b1);
    addr_c = 3'd3;
    #1;
    chk_rst(1'b0);
    @(posedge clk);
    #2 nrst = 1'b1;

    run_instr(2, 3, 1'b0, 0, 0);

    for (int n = 0; n < 3; n++) run_instr(0, 0, 1'b0, 0, 0);

    run_instr(1, 1, 1'b1, 0, 0);
    run_instr(2, 1, 1'b0, 0, 2);

    late_op = 5;
    run_instr(1, 2, 1'b0, 0, 0);
    late_op = -1;

    force_ph = PH_ADDR;
    force_t  = 1;
    force_n  = 3;
    run_instr(2, 1, 1'b0, 0, 0);
    force_t  = -1;

    do_cycle(PH_ADDR, 0, 1, 0, 1, 4, 1'b0, 0, 0);
    do_cycle(PH_ADDR, 1, 1, 1, 1, 4, 1'b0, 0, 0);
    do_cycle(PH_OP,   0, 4, 2, 1, 4, 1'b0, 0, 0);
    do_cycle(PH_OP,   1, 4, 3, 1, 4, 1'b0, 0, 0);
    do_cycle(PH_OP,   2, 4, 4, 1, 4, 1'b0, 0, 0);
    #2 nrst = 1'b0;
    addr_c = 3'd2;
    #1;
    chk_rst(1'b0);
    @(posedge clk);
    #2 nrst = 1'b1;
    run_instr(3, 2, 1'b0, 0, 0);

    run_instr(7, 7, 1'b1, 0, 0);

    for (int n = 0; n < 150; n++)
      run_instr(int'($urandom_range(7)), int'($urandom_range(7)), 1'($urandom), 20, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_timing_sequencer.md
# cpu_timing_sequencer

Parametrised successor to the CPU's addressing/operation timing generator. It sequences each instruction through an addressing phase, an operation phase and an optional interrupt-entry phase, and emits a per-phase cycle index (T-state) to the control-logic state machine. Compared with the original generator it adds:
- configurable timing-code width
- a `ready` stall input
- code latching at phase entry
- an interrupt-entry phase
- an instruction cycle counter

It sits between the instruction decoder (which supplies timing codes) and the control-logic state machine inside `top8227`.

## Interface
- `TW`, 3: width of timing codes and `timeOut`.
- `INT_CYCLES`, 7: length of the interrupt-entry phase in cycles (1 ≤ INT_CYCLES ≤ 2^TW).
- `CW`, 4: width of `instrCycles`.

- `clk` in 1: single clock, rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `ready` in 1: 1 = advance this cycle, 0 = hold all state.
- `addressTimingCode` in TW: last T-index of the addressing phase.
- `opTimingCode` in TW: last T-index of the operation phase.
- `interruptPending` in 1: NMI/IRQ request, already arbitrated upstream.
- `timeOut` out TW: current T-index within the phase (0..len).
- `phase` out 2: current phase, `cpu_phase_t`.
- `isAddressing` out 1: `phase == PH_ADDR`.
- `isInterrupt` out 1: `phase == PH_INT`.
- `phaseStart` out 1: `timeOut == 0`.
- `lastCycle` out 1: current cycle is the final cycle of the phase.
- `instrCycles` out CW: cycles elapsed since the current instruction's `PH_ADDR` T0; saturates at all-ones.

## Operation
- State registers: `phase`, `count` (TW), `lenReg` (TW), `instrCycles`.
- Effective phase length:
  - `effLen = (count == 0) ? liveLen : lenReg`.
  - `liveLen` is `addressTimingCode` in `PH_ADDR`, `opTimingCode` in `PH_OP`, and `INT_CYCLES-1` in `PH_INT`.
- Code latching: on an advancing edge with `count == 0`, `lenReg <= liveLen`. Code changes after T0 have no effect on the current phase.
- `lastCycle = (count == effLen)`.
- On an advancing edge (`ready == 1`):
  - If `!lastCycle`: `count <= count + 1`.
  - Else: `count <= 0` and the phase transitions:
    - `PH_ADDR` → `PH_OP`.
    - `PH_OP` → `PH_INT` if `interruptPending`, else `PH_ADDR`.
    - `PH_INT` → `PH_ADDR`.
- `interruptPending` is sampled only on the advancing edge of the `PH_OP` last cycle and is ignored at all other times.
- `instrCycles`:
  - Cleared to 0 on entry to `PH_ADDR`.
  - Otherwise increments by 1 per advancing edge, saturating.
  - `PH_INT` cycles count toward the preceding instruction.
- `ready == 0`: `phase`, `count`, `lenReg` and `instrCycles` all hold. Combinational outputs follow live inputs only while `count == 0`.
- A timing code of 0 gives a single-cycle phase, with `phaseStart` and `lastCycle` both 1.
- `phase` never takes the value 2'b11. If it is ever reached, the next advancing edge goes to `PH_ADDR` with `count = 0`.

## Timing
- Reset values (asynchronous, while `nrst == 0`):
  - `phase = PH_ADDR`, `count = 0`, `lenReg = 0`, `instrCycles = 0`.
  - Hence `timeOut = 0`, `isAddressing = 1`, `isInterrupt = 0`, `phaseStart = 1`.
  - `lastCycle = (addressTimingCode == 0)`.
- Reset asserted mid-phase aborts immediately; no pending transition completes. After release, the first rising edge is an ordinary T0 advance.
- Phase duration is `len + 1` advancing cycles. A full instruction with no interrupt takes `addressTimingCode + opTimingCode + 2` cycles.
- Outputs are combinational from registers plus the live code at T0; there is no added latency.
- A `ready` low period stretches the current T-state exactly by its length.

## Structure
- Shared package `cpu_pkg`:
  - `typedef enum logic [1:0] cpu_phase_t {PH_ADDR = 0, PH_OP = 1, PH_INT = 2}`.
  - Default constants `TIMING_W = 3` and `INT_ENTRY_CYCLES = 7`.
- Single module; no sub-module is needed. The counter and phase FSM share one `always_ff` / `always_comb` pair.

## Test plan
- Reset then advance with addr=2, op=3, `ready` held at 1, no interrupt → `timeOut` runs 0,1,2 (ADDR) then 0,1,2,3 (OP) → ADDR; `instrCycles` reaches 6 on the last OP cycle, then clears.
- addr=0, op=0 → ADDR and OP alternate every cycle, with `phaseStart` and `lastCycle` high continuously.
- `interruptPending` = 1 only on the OP last cycle (op=1) → `PH_INT` for 7 cycles (`timeOut` 0..6, `isInterrupt` = 1), then ADDR. The same pulse given on the OP T0 is ignored.
- Change `opTimingCode` from 2 to 5 at OP T1 → OP still ends at T2, so the latched code wins.
- `ready` = 0 for 3 cycles at ADDR T1 (addr=2) → `timeOut` stays 1 for 4 cycles total, and `instrCycles` does not advance.
- Assert `nrst` low mid-OP at T2, asynchronously between edges → outputs go to reset values immediately. After release, ADDR T0 with `instrCycles` = 0.
